// File: rtl/fp_alu_pkg.sv
// Shared types and helpers for the floating-point ALU issue stage.
package fp_alu_pkg;

  localparam int unsigned FP_N    = 32;
  localparam int unsigned FP_TAGW = 4;
  localparam int unsigned FP_SELW = 3;

  localparam logic [FP_SELW-1:0] OP_ADD = 3'd1;
  localparam logic [FP_SELW-1:0] OP_SUB = 3'd2;
  localparam logic [FP_SELW-1:0] OP_MUL = 3'd3;
  localparam logic [FP_SELW-1:0] OP_DIV = 3'd4;
  localparam logic [FP_SELW-1:0] OP_CMP = 3'd5;

  typedef struct packed {
    logic [FP_N-1:0]    a;
    logic [FP_N-1:0]    b;
    logic [FP_SELW-1:0] sel;
    logic [FP_TAGW-1:0] tag;
  } fp_req_t;

  // Opcodes the ALU actually implements; everything else is masked.
  function automatic logic is_legal_op(input logic [FP_SELW-1:0] sel);
    return (sel >= OP_ADD) && (sel <= OP_CMP);
  endfunction

endpackage

// File: rtl/fp_req_fifo.sv
// Synchronous request FIFO with combinational head read and occupancy count.
module fp_req_fifo
  import fp_alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  fp_req_t       wdata,
  output fp_req_t       head,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fp_req_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp_alu_issue_stage.sv
// Issue/retire stage around the combinational FP ALU: request FIFO,
// head-driven ALU operands, registered result with tag and flags.
// Optional sticky exception flags: define FP_ALU_STICKY_FLAGS_EN.
module fp_alu_issue_stage
  import fp_alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned N    = FP_N,
  localparam int unsigned TAGW = FP_TAGW,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic [2:0]      in_sel,
  input  logic [TAGW-1:0] in_tag,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [2:0]      alu_sel,
  input  logic [N-1:0]    alu_res,
  input  logic            alu_of,
  input  logic            alu_uf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_res,
  output logic            out_of,
  output logic            out_uf,
  output logic            out_ill,
  output logic [TAGW-1:0] out_tag,
  output logic [LW-1:0]   level,
  input  logic            flag_clr,
  output logic            sticky_of,
  output logic            sticky_uf,
  output logic            sticky_ill
);

  fp_req_t     wreq;
  fp_req_t     head;
  logic        full;
  logic        empty;
  logic        push;
  logic        retire;
  logic        legal;
  logic [N-1:0] res_next;
  logic        of_next;
  logic        uf_next;
  logic        ill_next;

  assign wreq     = '{a: in_a, b: in_b, sel: in_sel, tag: in_tag};
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign retire   = !empty && (!out_valid || out_ready);

  fp_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (retire),
    .wdata (wreq),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // ALU operands follow the head entry; idle value is all zeros.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = '0;
    if (!empty) begin
      alu_a   = head.a;
      alu_b   = head.b;
      alu_sel = head.sel;
    end
  end

  // Result shaping: illegal opcodes force a zero result and mask ALU flags.
  always_comb begin
    legal    = is_legal_op(head.sel);
    res_next = legal ? alu_res : '0;
    of_next  = legal && alu_of;
    uf_next  = legal && alu_uf;
    ill_next = !legal;
  end

  // Output register: load on retire, drop valid when drained with no refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      out_of    <= 1'b0;
      out_uf    <= 1'b0;
      out_ill   <= 1'b0;
      out_tag   <= '0;
    end else if (retire) begin
      out_valid <= 1'b1;
      out_res   <= res_next;
      out_of    <= of_next;
      out_uf    <= uf_next;
      out_ill   <= ill_next;
      out_tag   <= head.tag;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef FP_ALU_STICKY_FLAGS_EN
  // Sticky flags: clear then OR in this retire's flags, so a set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_of  <= 1'b0;
      sticky_uf  <= 1'b0;
      sticky_ill <= 1'b0;
    end else begin
      sticky_of  <= (sticky_of  && !flag_clr) || (retire && of_next);
      sticky_uf  <= (sticky_uf  && !flag_clr) || (retire && uf_next);
      sticky_ill <= (sticky_ill && !flag_clr) || (retire && ill_next);
    end
  end
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign sticky_of       = 1'b0;
  assign sticky_uf       = 1'b0;
  assign sticky_ill      = 1'b0;
`endif

endmodule

// File: tb/tb_fp_alu_issue_stage.sv
// Randomized bench for fp_alu_issue_stage with a stand-in ALU and a
// queue-based reference model of the stage.
module tb_fp_alu_issue_stage;
  import fp_alu_pkg::*;

  localparam int unsigned N     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAGW  = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    in_a;
  logic [N-1:0]    in_b;
  logic [2:0]      in_sel;
  logic [TAGW-1:0] in_tag;
  logic [N-1:0]    alu_a;
  logic [N-1:0]    alu_b;
  logic [2:0]      alu_sel;
  logic [N-1:0]    alu_res;
  logic            alu_of;
  logic            alu_uf;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    out_res;
  logic            out_of;
  logic            out_uf;
  logic            out_ill;
  logic [TAGW-1:0] out_tag;
  logic [LW-1:0]   level;
  logic            flag_clr;
  logic            sticky_of;
  logic            sticky_uf;
  logic            sticky_ill;

  fp_alu_issue_stage #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .in_tag     (in_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_res    (alu_res),
    .alu_of     (alu_of),
    .alu_uf     (alu_uf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_of     (out_of),
    .out_uf     (out_uf),
    .out_ill    (out_ill),
    .out_tag    (out_tag),
    .level      (level),
    .flag_clr   (flag_clr),
    .sticky_of  (sticky_of),
    .sticky_uf  (sticky_uf),
    .sticky_ill (sticky_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: exact answers for the known vectors, a scrambled but
  // deterministic result elsewhere, and garbage with flags on illegal opcodes.
  function automatic logic [33:0] mock_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] sel);
    logic [31:0] r;
    if (sel == 3'd1 && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 2'b00};
    if (sel == 3'd3 && a == 32'h40000000 && b == 32'h40400000) return {32'h40C00000, 2'b00};
    if (sel == 3'd3 && a == 32'h7F000000 && b == 32'h7F000000) return {32'h7FFFFFFF, 2'b10};
    if (sel == 3'd5) return {29'd0, (a > b), (a < b), (a == b), 2'b00};
    if (sel == 3'd0 || sel > 3'd5) return {32'hDEADBEEF ^ a, 2'b11};
    r = (a * 32'd3) ^ b ^ {29'd0, sel};
    return {r, r[0] & r[1], r[2] & r[3]};
  endfunction

  always_comb {alu_res, alu_of, alu_uf} = mock_alu(alu_a, alu_b, alu_sel);

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [3:0]  tag;
  } req_s;

  req_s        q[$];
  logic        m_valid, m_of, m_uf, m_ill;
  logic [31:0] m_res;
  logic [3:0]  m_tag;
  logic        s_of, s_uf, s_ill;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0; m_res = '0; m_of = 1'b0; m_uf = 1'b0; m_ill = 1'b0; m_tag = '0;
    s_of = 1'b0; s_uf = 1'b0; s_ill = 1'b0;
  endtask

  // One clock of the stage's behaviour, using the inputs held across the edge.
  task automatic model_step();
    logic        ret;
    logic        psh;
    logic [33:0] r;
    req_s        h;
    req_s        n;
    ret = (q.size() != 0) && (!m_valid || out_ready);
    psh = in_valid && (q.size() < DEPTH);
    n.a = in_a; n.b = in_b; n.sel = in_sel; n.tag = in_tag;
`ifdef FP_ALU_STICKY_FLAGS_EN
    if (flag_clr) begin s_of = 1'b0; s_uf = 1'b0; s_ill = 1'b0; end
`endif
    if (ret) begin
      h = q.pop_front();
      if (h.sel >= 3'd1 && h.sel <= 3'd5) begin
        r = mock_alu(h.a, h.b, h.sel);
        m_res = r[33:2]; m_of = r[1]; m_uf = r[0]; m_ill = 1'b0;
      end else begin
        m_res = '0; m_of = 1'b0; m_uf = 1'b0; m_ill = 1'b1;
      end
      m_tag   = h.tag;
      m_valid = 1'b1;
`ifdef FP_ALU_STICKY_FLAGS_EN
      s_of  = s_of  | m_of;
      s_uf  = s_uf  | m_uf;
      s_ill = s_ill | m_ill;
`endif
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (psh) q.push_back(n);
  endtask

  task automatic compare_all();
    logic [31:0] ea, eb;
    logic [2:0]  es;
    ea = '0; eb = '0; es = '0;
    if (q.size() != 0) begin ea = q[0].a; eb = q[0].b; es = q[0].sel; end
    check("in_ready",   64'(in_ready),   64'(q.size() < DEPTH));
    check("level",      64'(level),      64'(q.size()));
    check("out_valid",  64'(out_valid),  64'(m_valid));
    check("out_res",    64'(out_res),    64'(m_res));
    check("out_of",     64'(out_of),     64'(m_of));
    check("out_uf",     64'(out_uf),     64'(m_uf));
    check("out_ill",    64'(out_ill),    64'(m_ill));
    check("out_tag",    64'(out_tag),    64'(m_tag));
    check("alu_a",      64'(alu_a),      64'(ea));
    check("alu_b",      64'(alu_b),      64'(eb));
    check("alu_sel",    64'(alu_sel),    64'(es));
    check("sticky_of",  64'(sticky_of),  64'(s_of));
    check("sticky_uf",  64'(sticky_uf),  64'(s_uf));
    check("sticky_ill", 64'(sticky_ill), 64'(s_ill));
  endtask

  // Drive one cycle of inputs, advance the model over the edge, then compare.
  task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] sel, input logic [3:0] tag,
                       input logic ordy, input logic clr);
    in_valid = iv; in_a = a; in_b = b; in_sel = sel; in_tag = tag;
    out_ready = ordy; flag_clr = clr;
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic ordy, input logic clr);
    cycle(1'b0, 32'd0, 32'd0, 3'd0, 4'd0, ordy, clr);
  endtask

  logic [31:0] hold_res;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; in_tag = '0;
    out_ready = 1'b0; flag_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;

    // Add: result one edge after acceptance.
    cycle(1'b1, 32'h3F800000, 32'h40000000, 3'd1, 4'd3, 1'b1, 1'b0);
    check("add_not_yet", 64'(out_valid), 64'(0));
    idle(1'b1, 1'b0);
    check("add_valid", 64'(out_valid), 64'(1));
    check("add_res", 64'(out_res), 64'(32'h40400000));
    check("add_tag", 64'(out_tag), 64'(3));
    idle(1'b1, 1'b0);
    check("add_drained", 64'(out_valid), 64'(0));

    // Mul then compare back to back.
    cycle(1'b1, 32'h40000000, 32'h40400000, 3'd3, 4'd1, 1'b1, 1'b0);
    cycle(1'b1, 32'h3F800000, 32'h40000000, 3'd5, 4'd2, 1'b1, 1'b0);
    check("mul_res", 64'(out_res), 64'(32'h40C00000));
    check("mul_tag", 64'(out_tag), 64'(1));
    idle(1'b1, 1'b0);
    check("cmp_res", 64'(out_res), 64'(32'h00000002));
    check("cmp_tag", 64'(out_tag), 64'(2));
    idle(1'b1, 1'b0);

    // Backpressure: six pushes, five accepted.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, $urandom, $urandom, 3'($urandom_range(1, 5)), 4'(i), 1'b0, 1'b0);
      if (i == 1) hold_res = out_res;
    end
    check("bp_level", 64'(level), 64'(4));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_tag", 64'(out_tag), 64'(0));
    check("bp_stable", 64'(out_res), 64'(hold_res));
    for (int k = 1; k <= 4; k++) begin
      idle(1'b1, 1'b0);
      check("drain_tag", 64'(out_tag), 64'(k));
    end
    idle(1'b1, 1'b0);
    check("drain_done", 64'(out_valid), 64'(0));

    // Overflow and sticky behaviour.
    cycle(1'b1, 32'h7F000000, 32'h7F000000, 3'd3, 4'd5, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check("ovf_of", 64'(out_of), 64'(1));
    check("ovf_res", 64'(out_res), 64'(32'h7FFFFFFF));
    idle(1'b1, 1'b0);
`ifdef FP_ALU_STICKY_FLAGS_EN
    check("sticky_of_hold", 64'(sticky_of), 64'(1));
`endif
    idle(1'b1, 1'b1);
    check("sticky_of_clr", 64'(sticky_of), 64'(0));

    // Illegal opcode masks ALU garbage and flags.
    cycle(1'b1, 32'h12345678, 32'h9ABCDEF0, 3'd7, 4'd6, 1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check("ill_res", 64'(out_res), 64'(0));
    check("ill_flag", 64'(out_ill), 64'(1));
    check("ill_of", 64'(out_of), 64'(0));
    check("ill_uf", 64'(out_uf), 64'(0));
`ifdef FP_ALU_STICKY_FLAGS_EN
    check("sticky_ill_set", 64'(sticky_ill), 64'(1));
`endif
    idle(1'b1, 1'b1);

    // Reset mid-operation discards everything in flight.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, $urandom, $urandom, 3'd2, 4'(8 + i), 1'b0, 1'b0);
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    check("pre_rst_level", 64'(level), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_level", 64'(level), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b0);
      check("no_stale", 64'(out_valid), 64'(0));
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
            3'($urandom_range(0, 7)), 4'($urandom),
            1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 5));
    for (int i = 0; i < 8; i++) idle(1'b1, 1'b0);
    check("final_empty", 64'(level), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
